// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM states, command and response payloads.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        CAPTURE   = 3'd3,
        RESP      = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
    } i2c_cmd_t;

    typedef struct packed {
        logic [7:0] rdata;
        logic       nack;
        logic       timeout;
        logic [1:0] retries;
    } i2c_rsp_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with occupancy output; DEPTH must be a power of two.
module i2c_cmd_fifo
    import i2c_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  i2c_cmd_t                 wdata,
    output i2c_cmd_t                 rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    i2c_cmd_t               mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push && !full, pop && !empty})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C byte commands and drives them one at a time into the single-byte master.
// Optional NACK retry is enabled with the macro I2C_SEQ_RETRY_EN.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TIMEOUT   = 100000,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [6:0]             cmd_addr,
    input  logic [7:0]             cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_nack,
    output logic                   rsp_timeout,
    output logic [1:0]             rsp_retries,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   idle,
    output logic                   m_start,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_data_in,
    output logic                   m_rw,
    input  logic [7:0]             m_data_out,
    input  logic                   m_ack_error,
    input  logic                   m_busy
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);
`ifdef I2C_SEQ_RETRY_EN
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
`else
    // Retries compiled out: a zero limit keeps the counter at 0.
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY) & 2'b00;
`endif

    seq_state_t         state, state_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic [1:0]         retry_cnt, retry_cnt_n;
    logic               busy_meta, busy_s;
    logic               push, pop, fifo_full, fifo_empty;
    i2c_cmd_t           head, cmd_in;
    i2c_rsp_t           rsp_q, rsp_n;
    logic               rsp_valid_n, m_start_n, m_rw_n, idle_n;
    logic [6:0]         m_addr_n;
    logic [7:0]         m_data_in_n;
    logic [LVL_W-1:0]   level_n;

    assign cmd_ready   = !fifo_full;
    assign push        = cmd_valid && cmd_ready;
    assign cmd_in      = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_nack    = rsp_q.nack;
    assign rsp_timeout = rsp_q.timeout;
    assign rsp_retries = rsp_q.retries;

    i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (cmd_in),
        .rdata (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Synchroniser resets to "busy" so nothing issues until the master is seen idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_meta <= 1'b1;
            busy_s    <= 1'b1;
        end else begin
            busy_meta <= m_busy;
            busy_s    <= busy_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            retry_cnt <= '0;
            rsp_q     <= '0;
            rsp_valid <= 1'b0;
            m_start   <= 1'b0;
            m_addr    <= '0;
            m_data_in <= '0;
            m_rw      <= 1'b0;
            idle      <= 1'b1;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            retry_cnt <= retry_cnt_n;
            rsp_q     <= rsp_n;
            rsp_valid <= rsp_valid_n;
            m_start   <= m_start_n;
            m_addr    <= m_addr_n;
            m_data_in <= m_data_in_n;
            m_rw      <= m_rw_n;
            idle      <= idle_n;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        retry_cnt_n = retry_cnt;
        rsp_n       = rsp_q;
        rsp_valid_n = rsp_valid;
        m_start_n   = m_start;
        m_addr_n    = m_addr;
        m_data_in_n = m_data_in;
        m_rw_n      = m_rw;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                retry_cnt_n = '0;
                if (!fifo_empty && !busy_s && !rsp_valid) begin
                    pop         = 1'b1;
                    m_addr_n    = head.addr;
                    m_data_in_n = head.wdata;
                    m_rw_n      = head.rw;
                    m_start_n   = 1'b1;
                    timer_n     = '0;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                if (busy_s) begin
                    m_start_n = 1'b0;
                    timer_n   = '0;
                    state_n   = WAIT_DONE;
                end else if (timer >= TMR_MAX) begin
                    m_start_n   = 1'b0;
                    rsp_n       = '{rdata: 8'h00, nack: 1'b0, timeout: 1'b1, retries: retry_cnt};
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy_s) begin
                    state_n = CAPTURE;
                end else if (timer >= TMR_MAX) begin
                    rsp_n       = '{rdata: 8'h00, nack: 1'b0, timeout: 1'b1, retries: retry_cnt};
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            CAPTURE: begin
                if (m_ack_error && (retry_cnt < RETRY_LIMIT)) begin
                    retry_cnt_n = retry_cnt + 2'd1;
                    m_start_n   = 1'b1;
                    timer_n     = '0;
                    state_n     = ISSUE;
                end else begin
                    rsp_n       = '{rdata:   m_rw ? m_data_out : 8'h00,
                                    nack:    m_ack_error,
                                    timeout: 1'b0,
                                    retries: retry_cnt};
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Registered idle uses next-cycle occupancy so it lines up with fifo_level.
        level_n = fifo_level + LVL_W'(push) - LVL_W'(pop);
        idle_n  = (level_n == '0) && (state_n == IDLE) && !rsp_valid_n;
    end

endmodule
